// File: rtl/hazard_scoreboard_pkg.sv
// Shared constants and helpers for the hazard scoreboard.
// Register-index defaults, zero register and clog2.
package hazard_scoreboard_pkg;

  localparam int REG_ADDR_WIDTH_DEF = 5;
  localparam int ZERO_REG = 0;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

endpackage

// File: rtl/hazard_port_cmp.sv
// Single decode read-port hazard compare.
// Busy lookup with zero-register and writeback-bypass masking.
module hazard_port_cmp
  import hazard_scoreboard_pkg::*;
#(
  parameter int W         = REG_ADDR_WIDTH_DEF,
  parameter int DEPTH     = 2 ** W,
  parameter int WB_BYPASS = 1
) (
  input  logic             rvalid,
  input  logic [W-1:0]     raddr,
  input  logic [DEPTH-1:0] busy,
  input  logic             wb_valid,
  input  logic [W-1:0]     wb_waddr,
  output logic             hit
);

  logic nz;
  logic byp;

  // Hit when the operand is used, busy, not x0 and not cleared this cycle
  always_comb begin
    nz  = (raddr != W'(ZERO_REG));
    byp = (WB_BYPASS != 0) && wb_valid
        && (wb_waddr == raddr);
    hit = rvalid && busy[raddr] && nz && !byp;
  end

endmodule

// File: rtl/hazard_scoreboard.sv
// Per-register busy scoreboard for variable-latency producers.
// Stalls decode on RAW, WAW and outstanding-limit; stall counters.
module hazard_scoreboard
  import hazard_scoreboard_pkg::*;
#(
  parameter int REG_ADDR_WIDTH  = REG_ADDR_WIDTH_DEF,
  parameter int NUM_RPORTS      = 2,
  parameter int MAX_OUTSTANDING = 4,
  parameter int WB_BYPASS       = 1,
  parameter int STALL_CNT_WIDTH = 8,
  parameter int PERF_CNT_WIDTH  = 32,
  localparam int DEPTH = 2 ** REG_ADDR_WIDTH,
  localparam int OUT_W = clog2(MAX_OUTSTANDING + 1),
  localparam int RA_W  = NUM_RPORTS * REG_ADDR_WIDTH
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       issue_valid,
  input  logic [REG_ADDR_WIDTH-1:0]  issue_waddr,
  input  logic                       wb_valid,
  input  logic [REG_ADDR_WIDTH-1:0]  wb_waddr,
  input  logic [NUM_RPORTS-1:0]      dec_rvalid,
  input  logic [RA_W-1:0]            dec_raddr,
  input  logic                       dec_wen,
  input  logic [REG_ADDR_WIDTH-1:0]  dec_waddr,
  output logic                       hazard_detected,
  output logic [NUM_RPORTS-1:0]      raw_hit,
  output logic                       waw_hit,
  output logic                       full,
  output logic [DEPTH-1:0]           busy_vec,
  output logic [OUT_W-1:0]           outstanding,
  output logic [STALL_CNT_WIDTH-1:0] stall_run,
  output logic [PERF_CNT_WIDTH-1:0]  stall_total
);

  localparam logic [REG_ADDR_WIDTH-1:0] ZR =
    REG_ADDR_WIDTH'(ZERO_REG);

  logic [DEPTH-1:0]           busy_q, busy_d;
  logic [OUT_W-1:0]           outstanding_q, outstanding_d;
  logic [STALL_CNT_WIDTH-1:0] stall_run_q, stall_run_d;
  logic [PERF_CNT_WIDTH-1:0]  stall_total_q, stall_total_d;

  logic set, clr, same, set_eff, clr_eff;

  for (genvar i = 0; i < NUM_RPORTS; i++) begin : g_port
    hazard_port_cmp #(
      .W         (REG_ADDR_WIDTH),
      .DEPTH     (DEPTH),
      .WB_BYPASS (WB_BYPASS)
    ) u_cmp (
      .rvalid   (dec_rvalid[i]),
      .raddr    (dec_raddr[i*REG_ADDR_WIDTH +: REG_ADDR_WIDTH]),
      .busy     (busy_q),
      .wb_valid (wb_valid),
      .wb_waddr (wb_waddr),
      .hit      (raw_hit[i])
    );
  end

  // Stall decision from registered state and current decode
  always_comb begin
    waw_hit = dec_wen && busy_q[dec_waddr]
            && (dec_waddr != ZR);
    full = (outstanding_q == OUT_W'(MAX_OUTSTANDING));
    hazard_detected = (|raw_hit) || waw_hit
                    || (full && dec_wen);
  end

  // Next scoreboard: a same-index issue overrides the clear
  always_comb begin
    busy_d  = busy_q;
    set     = issue_valid && (issue_waddr != ZR);
    clr     = wb_valid && (wb_waddr != ZR)
            && busy_q[wb_waddr];
    same    = (issue_waddr == wb_waddr);
    set_eff = set && !busy_q[issue_waddr];
    clr_eff = clr && !(set && same);
    if (clr_eff) busy_d[wb_waddr] = 1'b0;
    if (set) busy_d[issue_waddr] = 1'b1;
    outstanding_d = outstanding_q + OUT_W'(set_eff)
                  - OUT_W'(clr_eff);
  end

  // Next stall counters: saturating run, wrapping total
  always_comb begin
    stall_run_d = '0;
    if (hazard_detected) begin
      if (&stall_run_q) stall_run_d = stall_run_q;
      else stall_run_d = stall_run_q + STALL_CNT_WIDTH'(1);
    end
    stall_total_d = stall_total_q
                  + PERF_CNT_WIDTH'(hazard_detected);
  end

  // State registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      busy_q        <= '0;
      outstanding_q <= '0;
      stall_run_q   <= '0;
      stall_total_q <= '0;
    end else begin
      busy_q        <= busy_d;
      outstanding_q <= outstanding_d;
      stall_run_q   <= stall_run_d;
      stall_total_q <= stall_total_d;
    end
  end

  assign busy_vec    = busy_q;
  assign outstanding = outstanding_q;
  assign stall_run   = stall_run_q;
  assign stall_total = stall_total_q;

  a_issue_stall: assert property (@(posedge clk) disable iff (!rst_n)
    !(issue_valid && hazard_detected));
  a_issue_busy: assert property (@(posedge clk) disable iff (!rst_n)
    (issue_valid && issue_waddr != ZR && busy_q[issue_waddr])
    |-> (wb_valid && wb_waddr == issue_waddr));
  a_wb_idle: assert property (@(posedge clk) disable iff (!rst_n)
    (wb_valid && wb_waddr != ZR) |-> busy_q[wb_waddr]);
  a_out_max: assert property (@(posedge clk) disable iff (!rst_n)
    outstanding_q <= OUT_W'(MAX_OUTSTANDING));
  a_out_pop: assert property (@(posedge clk) disable iff (!rst_n)
    $countones(busy_q) == int'(outstanding_q));

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard.
// Expected values queued on drive, popped and checked on sample.
module tb_hazard_scoreboard;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        issue_valid;
  logic [4:0]  issue_waddr;
  logic        wb_valid;
  logic [4:0]  wb_waddr;
  logic [1:0]  dec_rvalid;
  logic [9:0]  dec_raddr;
  logic        dec_wen;
  logic [4:0]  dec_waddr;
  logic        hazard_detected;
  logic [1:0]  raw_hit;
  logic        waw_hit;
  logic        full;
  logic [31:0] busy_vec;
  logic [2:0]  outstanding;
  logic [7:0]  stall_run;
  logic [31:0] stall_total;

  typedef struct {
    string       tag;
    logic [63:0] v;
  } exp_t;

  exp_t exp_q[$];
  int checks = 0;
  int failures = 0;

  hazard_scoreboard dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .issue_valid     (issue_valid),
    .issue_waddr     (issue_waddr),
    .wb_valid        (wb_valid),
    .wb_waddr        (wb_waddr),
    .dec_rvalid      (dec_rvalid),
    .dec_raddr       (dec_raddr),
    .dec_wen         (dec_wen),
    .dec_waddr       (dec_waddr),
    .hazard_detected (hazard_detected),
    .raw_hit         (raw_hit),
    .waw_hit         (waw_hit),
    .full            (full),
    .busy_vec        (busy_vec),
    .outstanding     (outstanding),
    .stall_run       (stall_run),
    .stall_total     (stall_total)
  );

  always #5 clk = ~clk;

  task automatic push(input string tag, input logic [63:0] v);
    exp_t e;
    e.tag = tag;
    e.v = v;
    exp_q.push_back(e);
  endtask

  task automatic chk(input logic [63:0] obs);
    exp_t e;
    checks++;
    if (exp_q.size() == 0) begin
      failures++;
      $error("FAIL sb_underflow observed=%0h expected=none", obs);
    end else begin
      e = exp_q.pop_front();
      assert (obs === e.v) else begin
        failures++;
        $error("FAIL %s observed=%0h expected=%0h",
               e.tag, obs, e.v);
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    issue_valid = 1'b0;
    issue_waddr = '0;
    wb_valid    = 1'b0;
    wb_waddr    = '0;
    dec_rvalid  = '0;
    dec_raddr   = '0;
    dec_wen     = 1'b0;
    dec_waddr   = '0;
  endtask

  task automatic do_reset();
    idle();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    idle();
    tick();
    tick();
    rst_n = 1'b1;
    // reset state
    push("rst_busy", 0);
    push("rst_out", 0);
    push("rst_run", 0);
    push("rst_total", 0);
    push("rst_hz", 0);
    #1;
    chk(busy_vec);
    chk(outstanding);
    chk(stall_run);
    chk(stall_total);
    chk(hazard_detected);

    // load-use
    issue_valid = 1'b1;
    issue_waddr = 5'd5;
    tick();
    issue_valid = 1'b0;
    dec_rvalid = 2'b01;
    dec_raddr = {5'd0, 5'd5};
    push("lu_hz1", 1);
    push("lu_raw1", 2'b01);
    push("lu_busy1", 1);
    push("lu_out1", 1);
    #1;
    chk(hazard_detected);
    chk(raw_hit);
    chk(busy_vec[5]);
    chk(outstanding);
    tick();
    push("lu_hz2", 1);
    push("lu_run2", 1);
    #1;
    chk(hazard_detected);
    chk(stall_run);
    tick();
    wb_valid = 1'b1;
    wb_waddr = 5'd5;
    push("lu_hz3_byp", 0);
    push("lu_raw3", 0);
    push("lu_run3", 2);
    push("lu_busy3", 1);
    #1;
    chk(hazard_detected);
    chk(raw_hit);
    chk(stall_run);
    chk(busy_vec[5]);
    tick();
    wb_valid = 1'b0;
    push("lu_busy4", 0);
    push("lu_run4", 0);
    push("lu_total4", 2);
    push("lu_hz4", 0);
    push("lu_out4", 0);
    #1;
    chk(busy_vec[5]);
    chk(stall_run);
    chk(stall_total);
    chk(hazard_detected);
    chk(outstanding);

    // zero register
    do_reset();
    issue_valid = 1'b1;
    issue_waddr = 5'd0;
    tick();
    issue_valid = 1'b0;
    dec_rvalid = 2'b11;
    dec_raddr = {5'd0, 5'd0};
    dec_wen = 1'b1;
    dec_waddr = 5'd0;
    push("z_busy", 0);
    push("z_hz", 0);
    push("z_out", 0);
    #1;
    chk(busy_vec);
    chk(hazard_detected);
    chk(outstanding);

    // WAW
    do_reset();
    issue_valid = 1'b1;
    issue_waddr = 5'd7;
    tick();
    idle();
    dec_wen = 1'b1;
    dec_waddr = 5'd7;
    push("waw_hit1", 1);
    push("waw_hz1", 1);
    push("waw_raw1", 0);
    #1;
    chk(waw_hit);
    chk(hazard_detected);
    chk(raw_hit);
    tick();
    wb_valid = 1'b1;
    wb_waddr = 5'd7;
    push("waw_hit_wb", 1);
    #1;
    chk(waw_hit);
    tick();
    wb_valid = 1'b0;
    push("waw_hit_next", 0);
    push("waw_busy_next", 0);
    #1;
    chk(waw_hit);
    chk(busy_vec);

    // full
    do_reset();
    for (int r = 1; r <= 4; r++) begin
      issue_valid = 1'b1;
      issue_waddr = 5'(r);
      tick();
    end
    issue_valid = 1'b0;
    dec_wen = 1'b1;
    dec_waddr = 5'd9;
    push("f_full", 1);
    push("f_out", 4);
    push("f_busy", 32'h1e);
    push("f_hz_wen", 1);
    push("f_waw", 0);
    #1;
    chk(full);
    chk(outstanding);
    chk(busy_vec);
    chk(hazard_detected);
    chk(waw_hit);
    dec_wen = 1'b0;
    dec_rvalid = 2'b01;
    dec_raddr = {5'd0, 5'd9};
    push("f_hz_read", 0);
    #1;
    chk(hazard_detected);

    // simultaneous set and clear
    do_reset();
    issue_valid = 1'b1;
    issue_waddr = 5'd3;
    tick();
    wb_valid = 1'b1;
    wb_waddr = 5'd3;
    tick();
    push("s_same_busy", 32'h8);
    push("s_same_out", 1);
    #1;
    chk(busy_vec);
    chk(outstanding);
    issue_waddr = 5'd6;
    tick();
    idle();
    push("s_diff_busy", 32'h40);
    push("s_diff_out", 1);
    #1;
    chk(busy_vec);
    chk(outstanding);

    // counters and mid-run reset
    do_reset();
    issue_valid = 1'b1;
    issue_waddr = 5'd5;
    tick();
    issue_valid = 1'b0;
    dec_rvalid = 2'b10;
    dec_raddr = {5'd5, 5'd0};
    for (int k = 0; k < 255; k++) tick();
    push("c_run255", 255);
    push("c_raw_p1", 2'b10);
    #1;
    chk(stall_run);
    chk(raw_hit);
    for (int k = 0; k < 45; k++) tick();
    push("c_run_sat", 255);
    push("c_total", 300);
    #1;
    chk(stall_run);
    chk(stall_total);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    push("r_busy", 0);
    push("r_out", 0);
    push("r_run", 0);
    push("r_total", 0);
    push("r_hz", 0);
    push("r_raw", 0);
    push("r_full", 0);
    #1;
    chk(busy_vec);
    chk(outstanding);
    chk(stall_run);
    chk(stall_total);
    chk(hazard_detected);
    chk(raw_hit);
    chk(full);

    if (exp_q.size() != 0) begin
      failures++;
      $error("FAIL sb_leftover observed=%0d expected=0",
             exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
